// File: rtl/io_timer_pkg.sv
// rtl/io_timer_pkg.sv - register map, bit positions and reset constants for io_timer
package io_timer_pkg;

    // Register offsets within the 4-byte window
    typedef enum logic [1:0] {
        CTRL_OFS  = 2'd0,
        COUNT_OFS = 2'd1,
        CMP_OFS   = 2'd2,
        STAT_OFS  = 2'd3
    } reg_ofs_e;

    // CTRL bit positions
    localparam int EN     = 0;
    localparam int CLRM   = 1;
    localparam int MIE    = 2;
    localparam int OIE    = 3;
    localparam int PS_LSB = 4;
    localparam int PS_MSB = 6;

    // STAT bit positions
    localparam int MF = 0;
    localparam int OF = 1;

    localparam logic [7:0] CMP_RST = 8'hFF;

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - 7-bit prescaler producing a tick every 2^ps enabled cycles
// Ports: clk, rst_n (async, active low), en (count enable), clr (restart from 0),
//        ps[2:0] (log2 of tick period), tick (1-cycle pulse, combinational).
module timer_prescaler
    import io_timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    input  logic [2:0] ps,
    output logic       tick
);

    logic [6:0] cnt;
    logic [6:0] mask;

    // Low ps bits set; ps=0 gives an empty mask so every enabled cycle ticks.
    always_comb begin
        mask = ~(7'h7F << ps);
        tick = en & ((cnt & mask) == mask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 7'd0;
        end else if (clr || !en) begin
            cnt <= 7'd0;
        end else begin
            cnt <= cnt + 7'd1;
        end
    end

endmodule

// File: rtl/io_timer.sv
// rtl/io_timer.sv - memory-mapped 8-bit timer with compare match, overflow and level IRQ
// Ports: clk, rst_n (async, active low), address[15:0], dataIn[7:0], writeEn, readEn,
//        dataOut[7:0] (registered, 0 when not read), interrupt (level, active high).
module io_timer
    import io_timer_pkg::*;
#(
    parameter logic [15:0] BASE = 16'h1000
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] address,
    input  logic [7:0]  dataIn,
    input  logic        writeEn,
    input  logic        readEn,
    output logic [7:0]  dataOut,
    output logic        interrupt
);

    logic       sel;
    logic [1:0] ofs;
    logic       ctrl_wr, count_wr, cmp_wr, stat_wr;
    logic [7:0] ctrl, count, cmp;
    logic       flag_mf, flag_of;
    logic       tick, tick_eff, step, match, wrap_clr, mf_set, of_set;
    logic [7:0] count_nxt, rd_data;

    always_comb begin
        sel      = (address[15:2] == BASE[15:2]);
        ofs      = address[1:0];
        ctrl_wr  = sel & writeEn & (ofs == CTRL_OFS);
        count_wr = sel & writeEn & (ofs == COUNT_OFS);
        cmp_wr   = sel & writeEn & (ofs == CMP_OFS);
        stat_wr  = sel & writeEn & (ofs == STAT_OFS);
    end

    timer_prescaler u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ctrl[EN]),
        .clr   (ctrl_wr),
        .ps    (ctrl[PS_MSB:PS_LSB]),
        .tick  (tick)
    );

    // A CTRL write that drops EN kills the tick of that same cycle; a COUNT
    // write overrides the tick entirely, including its flag side effects.
    always_comb begin
        tick_eff  = tick & ~(ctrl_wr & ~dataIn[EN]);
        step      = tick_eff & ~count_wr;
        match     = (count == cmp);
        wrap_clr  = match & ctrl[CLRM];
        mf_set    = step & match;
        // Match with CLRM=0 at 0xFF still wraps, so overflow is flagged too.
        of_set    = step & (count == 8'hFF) & ~wrap_clr;
        count_nxt = count;
        if (count_wr) begin
            count_nxt = dataIn;
        end else if (step) begin
            count_nxt = wrap_clr ? 8'h00 : count + 8'd1;
        end
    end

    always_comb begin
        rd_data = 8'h00;
        case (ofs)
            CTRL_OFS:  rd_data = ctrl;
            COUNT_OFS: rd_data = count;
            CMP_OFS:   rd_data = cmp;
            STAT_OFS:  rd_data = {6'd0, flag_of, flag_mf};
            default:   rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl      <= 8'h00;
            count     <= 8'h00;
            cmp       <= CMP_RST;
            flag_mf   <= 1'b0;
            flag_of   <= 1'b0;
            dataOut   <= 8'h00;
            interrupt <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                ctrl <= {1'b0, dataIn[6:0]};
            end
            if (cmp_wr) begin
                cmp <= dataIn;
            end
            count <= count_nxt;
            // Set beats write-1-to-clear
            flag_mf <= mf_set | (flag_mf & ~(stat_wr & dataIn[MF]));
            flag_of <= of_set | (flag_of & ~(stat_wr & dataIn[OF]));
            // Read mux sees pre-write register values
            dataOut   <= (sel & readEn) ? rd_data : 8'h00;
            interrupt <= (flag_mf & ctrl[MIE]) | (flag_of & ctrl[OIE]);
        end
    end

endmodule
